stream_rr_arbiter: RTL

STREAM_RR_ARBITER -- requirements
Module: stream_rr_arbiter

---
 rtl/stream_rr_arbiter_if.sv | 33 +++
 rtl/stream_rr_arbiter.sv | 100 ++++++++++
 2 files changed

// File: rtl/stream_rr_arbiter_if.sv
// Stream bundle between N requesters and the round-robin arbiter.
//   in_valid/in_ready/in_data/in_last : N request streams, requester i data
//                                       in in_data[i*WIDTH +: WIDTH]
//   out_valid/out_ready/out_data/out_last/out_id : merged output stream
// Modports:
//   master : the arbiter (drives in_ready and the out_* stream)
//   slave  : the environment (requesters plus downstream sink)
interface stream_rr_arbiter_if #(
    parameter int WIDTH = 32,
    parameter int N     = 4
);
    localparam int IDW = (N > 2) ? $clog2(N) : 1;

    logic [N-1:0]       in_valid;
    logic [N-1:0]       in_ready;
    logic [N*WIDTH-1:0] in_data;
    logic [N-1:0]       in_last;
    logic [WIDTH-1:0]   out_data;
    logic               out_last;
    logic [IDW-1:0]     out_id;
    logic               out_valid;
    logic               out_ready;

    modport master (
        input  in_valid, in_data, in_last, out_ready,
        output in_ready, out_data, out_last, out_id, out_valid
    );

    modport slave (
        output in_valid, in_data, in_last, out_ready,
        input  in_ready, out_data, out_last, out_id, out_valid
    );
endinterface

// File: rtl/stream_rr_arbiter.sv
// Packet-aware round-robin arbiter merging N valid/ready streams into one
// registered output stream. A requester that wins keeps the grant until its
// last beat is accepted; the search pointer then moves just past it.
// Ports:
//   clk  : clock, rising edge
//   rst  : synchronous active-high reset
//   busy : high while a multi-beat packet holds the lock
//   bus  : stream bundle (master modport), see stream_rr_arbiter_if
module stream_rr_arbiter #(
    parameter int WIDTH = 32,
    parameter int N     = 4
) (
    input  logic                clk,
    input  logic                rst,
    output logic                busy,
    stream_rr_arbiter_if.master bus
);
    localparam int IDW = (N > 2) ? $clog2(N) : 1;

    typedef enum logic {IDLE, LOCKED} state_t;

    state_t         state, state_next;
    logic [IDW-1:0] ptr, lock_id, winner, src;
    logic           found, can_load, accept, src_last;
    logic [WIDTH-1:0] src_data;

    assign can_load = ~bus.out_valid | bus.out_ready;

    // Rotating priority search starting at ptr. Iterating from the farthest
    // offset down lets the nearest valid requester overwrite the result.
    always_comb begin : search
        logic [IDW:0] idx;
        idx    = '0;
        winner = '0;
        found  = 1'b0;
        for (int k = N - 1; k >= 0; k--) begin
            idx = {1'b0, ptr} + (IDW+1)'(k);
            if (idx >= (IDW+1)'(N))
                idx = idx - (IDW+1)'(N);
            if (bus.in_valid[idx[IDW-1:0]]) begin
                winner = idx[IDW-1:0];
                found  = 1'b1;
            end
        end
    end

    // While locked the grant is fixed, so in_ready never looks at in_valid.
    always_comb begin
        bus.in_ready = '0;
        if (state == LOCKED)
            bus.in_ready[lock_id] = can_load;
        else if (can_load && found)
            bus.in_ready[winner] = 1'b1;
    end

    assign src      = (state == LOCKED) ? lock_id : winner;
    assign accept   = |(bus.in_valid & bus.in_ready);
    assign src_data = bus.in_data[int'(src)*WIDTH +: WIDTH];
    assign src_last = bus.in_last[src];
    assign busy     = (state == LOCKED);

    always_comb begin
        state_next = state;
        if (accept)
            state_next = src_last ? IDLE : LOCKED;
    end

    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_next;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr           <= '0;
            lock_id       <= '0;
            bus.out_valid <= 1'b0;
            bus.out_data  <= '0;
            bus.out_last  <= 1'b0;
            bus.out_id    <= '0;
        end else begin
            if (accept) begin
                // Load and drain may coincide: the new beat simply replaces
                // the departing one, so out_valid stays high.
                bus.out_valid <= 1'b1;
                bus.out_data  <= src_data;
                bus.out_last  <= src_last;
                bus.out_id    <= src;
                if (src_last)
                    ptr <= (src == IDW'(N - 1)) ? '0 : src + 1'b1;
                else
                    lock_id <= src;
            end else if (bus.out_ready) begin
                bus.out_valid <= 1'b0;
            end
        end
    end
endmodule
